// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// mdu_ctrl_pkg : shared opcodes, default latencies and decode helpers for MDU
// Rev 1.0
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op != MDU_NONE) && (op <= MDU_MTLO);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// mdu_arith : combinational 32x32 multiply / divide producing {hi, lo}
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div0_o
);

  logic        w_b_zero;
  logic [31:0] w_div_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq;
  logic [31:0] w_sr;

  assign w_b_zero = (b_i == 32'd0);
  // Divisor is forced nonzero; div0 results are discarded by the controller.
  assign w_div_b  = w_b_zero ? 32'd1 : b_i;
  assign w_abs_a  = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign w_abs_b  = w_div_b[31] ? (~w_div_b + 32'd1) : w_div_b;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
  assign w_uq = w_abs_a / w_abs_b;
  assign w_ur = w_abs_a % w_abs_b;
  assign w_sq = (a_i[31] ^ w_div_b[31]) ? (~w_uq + 32'd1) : w_uq;
  assign w_sr = a_i[31] ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    result_o = 64'd0;
    case (op_i)
      MDU_MULT:  result_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      MDU_MULTU: result_o = {32'd0, a_i} * {32'd0, b_i};
      MDU_DIV:   result_o = {w_sr, w_sq};
      MDU_DIVU:  result_o = {a_i % w_div_b, a_i / w_div_b};
      default:   result_o = 64'd0;
    endcase
  end

  assign div0_o = w_b_zero && ((op_i == MDU_DIV) || (op_i == MDU_DIVU));

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// mdu_ctrl : E-stage multiply/divide sequencer owning HI/LO and stall request
// Rev 1.0
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        start,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;

  logic             w_accept;
  logic             w_is_mult;
  logic [63:0]      w_result;
  logic             w_div0;

  mdu_arith u_arith (
    .op_i     (mdu_op),
    .a_i      (rs_val),
    .b_i      (rt_val),
    .result_o (w_result),
    .div0_o   (w_div0)
  );

  assign busy      = (cnt_q != '0);
  assign stall_req = en & is_md_op(mdu_op) & busy;
  assign w_accept  = en & ~stall_req;
  assign start     = w_accept & is_muldiv(mdu_op);
  assign w_is_mult = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (start) begin
      cnt_d = w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      // Divide by zero commits the current HI/LO, leaving them unchanged.
      if (w_div0) begin
        pend_hi_d = hi_q;
        pend_lo_d = lo_q;
      end else begin
        pend_hi_d = w_result[63:32];
        pend_lo_d = w_result[31:0];
      end
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (cnt_q == CNT_W'(1)) begin
      cnt_d = '0;
      hi_d  = pend_hi_q;
      lo_d  = pend_lo_q;
    end

    // Moves to HI/LO are only accepted while idle, so they never collide with commit.
    if (w_accept && (mdu_op == MDU_MTHI)) hi_d = rs_val;
    if (w_accept && (mdu_op == MDU_MTLO)) lo_d = rs_val;
  end

  always_comb begin
    mdu_out = 32'd0;
    if (w_accept && (mdu_op == MDU_MFHI)) mdu_out = hi_q;
    if (w_accept && (mdu_op == MDU_MFLO)) mdu_out = lo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// tb_mdu_ctrl : directed self-checking bench for mdu_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_OTHER = 4'd9;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        start;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mdu_op    (mdu_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .start     (start),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo),
    .mdu_out   (mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    en     = e;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
  endtask

  // Issue a mult/div, keep a non-MDU op on the bus while busy, then check the commit.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(1'b1, op, a, b);
    #1;
    chk({tag, " start"}, {31'd0, start}, 32'd1);
    chk({tag, " no stall at issue"}, {31'd0, stall_req}, 32'd0);
    tick();
    drive(1'b1, OP_OTHER, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    #1;
    for (int i = 0; i < lat; i++) begin
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " start low"}, {31'd0, start}, 32'd0);
      chk({tag, " non-md no stall"}, {31'd0, stall_req}, 32'd0);
      chk({tag, " hi held"}, hi, old_hi);
      chk({tag, " lo held"}, lo, old_lo);
      tick();
    end
    chk({tag, " busy drop"}, {31'd0, busy}, 32'd0);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    tick();
    tick();
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset stall", {31'd0, stall_req}, 32'd0);
    chk("reset mdu_out", mdu_out, 32'd0);
    reset = 1'b0;
    tick();

    run_md("MULT", OP_MULT, 32'hFFFF_FFFD, 32'd5, 5,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_md("MULTU", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_md("DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10,
           32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("DIVU", OP_DIVU, 32'd7, 32'd2, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);
    run_md("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'd1, 32'd3, 32'd0, 32'h8000_0000);

    // MFLO right behind a DIV must stall with zero output until the commit.
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    #1;
    chk("DIV2 start", {31'd0, start}, 32'd1);
    tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("MFLO stalled", {31'd0, stall_req}, 32'd1);
      chk("MFLO out zero", mdu_out, 32'd0);
      chk("MFLO no start", {31'd0, start}, 32'd0);
      tick();
    end
    chk("MFLO released", {31'd0, stall_req}, 32'd0);
    chk("MFLO value", mdu_out, 32'd14);
    chk("DIV2 hi", hi, 32'd2);

    drive(1'b1, OP_MTHI, 32'h0000_1234, 32'd0);
    #1;
    chk("MTHI no start", {31'd0, start}, 32'd0);
    chk("MTHI no stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("MTHI hi", hi, 32'h0000_1234);
    chk("MTHI lo kept", lo, 32'd14);
    chk("MTHI not busy", {31'd0, busy}, 32'd0);

    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    #1;
    chk("MFHI value", mdu_out, 32'h0000_1234);
    drive(1'b0, OP_MFHI, 32'd0, 32'd0);
    #1;
    chk("MFHI en low", mdu_out, 32'd0);

    run_md("DIV0", OP_DIV, 32'd5, 32'd0, 10,
           32'h0000_1234, 32'd14, 32'h0000_1234, 32'd14);

    drive(1'b1, OP_MTLO, 32'h0000_ABCD, 32'd0);
    tick();
    chk("MTLO lo", lo, 32'h0000_ABCD);
    chk("MTLO hi kept", hi, 32'h0000_1234);

    // Flushed MDU op while busy: not stalled, and the mult still commits.
    drive(1'b1, OP_MULT, 32'd3, 32'd4);
    tick();
    drive(1'b0, OP_MULT, 32'd9, 32'd9);
    #1;
    chk("flush no stall", {31'd0, stall_req}, 32'd0);
    chk("flush no start", {31'd0, start}, 32'd0);
    repeat (5) tick();
    chk("flush commit lo", lo, 32'd12);
    chk("flush commit hi", hi, 32'd0);

    drive(1'b1, OP_MULT, 32'd3, 32'd4);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    drive(1'b1, OP_MTHI, 32'h0000_5555, 32'd0);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    tick();
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    drive(1'b1, OP_MFHI, 32'd0, 32'd0);
    #1;
    chk("post-abort MFHI stall", {31'd0, stall_req}, 32'd0);
    chk("post-abort MFHI out", mdu_out, 32'd0);
    tick();
    drive(1'b0, OP_NONE, 32'd0, 32'd0);
    repeat (6) tick();
    chk("abort no late commit", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
